// File: rtl/cr_prefix_pkg.sv
// Shared cr_prefix definitions: the per-slot feature match configuration
// and the character compare helper used by the lane matchers.
package cr_prefix_pkg;

  localparam int CHAR_W = 8;

  // One slot's match criterion: a masked compare against value, optionally
  // chained with the prior-match bit of the same lane.
  typedef struct packed {
    logic [CHAR_W-1:0] value;
    logic [CHAR_W-1:0] mask;
    logic              prior_en;
  } feature_t;

  // Masked character compare: bits cleared in mask are don't-care.
  function automatic logic char_hit(input feature_t cfg, input logic [CHAR_W-1:0] ch);
    return ((ch ^ cfg.value) & cfg.mask) == '0;
  endfunction

endpackage

// File: rtl/cr_prefix_fe_lane.sv
// One byte-lane matcher: compares the lane character against the selected
// slot configuration and registers the qualified match bit.
module cr_prefix_fe_lane
  import cr_prefix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  feature_t          cfg,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              vbyte,
  input  logic              prior,
  output logic              match
);

  logic hit;

  // A lane hits only when it carries a valid byte, the masked compare holds
  // and, if chaining is enabled, the prior-match input for this lane is set.
  assign hit = vbyte & char_hit(cfg, char_in) & (~cfg.prior_en | prior);

  // Stage-1 match register; deliberately not touched by the block clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else begin
      match <= hit;
    end
  end

endmodule

// File: rtl/cr_prefix_fe_ctr_gen.sv
// Feature counter generator.
// Stage 1: per-lane matchers plus aligned copies of eodb and slot select.
// Stage 2: popcount of the match vector accumulated per data block; on the
// block-closing beat the total (including that beat) lands in the selected
// slot together with its sticky overflow flag, and fe_upd pulses.
// fe_clr acts on stage 2 only and takes priority over a coincident close.
module cr_prefix_fe_ctr_gen
  import cr_prefix_pkg::*;
#(
  parameter  int NUM_LANES = 8,
  parameter  int CTR_W     = 8,
  parameter  int NUM_BLK   = 4,
  localparam int SEL_W     = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  feature_t [NUM_BLK-1:0]      fe_config,
  input  logic [SEL_W-1:0]            fe_sel,
  input  logic [8*NUM_LANES-1:0]      fe_char_in,
  input  logic [NUM_LANES-1:0]        fe_char_vbytes,
  input  logic [NUM_LANES-1:0]        fe_prior_in,
  input  logic                        fe_eodb,
  input  logic                        fe_clr,
  input  logic                        fe_sat_mode,
  output logic [NUM_LANES-1:0]        fe_prior_out,
  output logic [NUM_BLK*CTR_W-1:0]    fe_ctr_blk,
  output logic [NUM_BLK-1:0]          fe_ctr_vld,
  output logic [NUM_BLK-1:0]          fe_ovf,
  output logic                        fe_upd
);

  localparam int SUM_W = $clog2(NUM_LANES + 1);

  logic [SEL_W-1:0]               sel_eff;
  feature_t                       cfg_cur;
  logic [NUM_LANES-1:0]           match_q;
  logic                           eodb_d;
  logic [SEL_W-1:0]               sel_d;
  logic [SUM_W-1:0]               sum;
  logic [CTR_W:0]                 nxt;
  logic                           beat_ovf;
  logic [CTR_W-1:0]               result;
  logic [CTR_W-1:0]               acc_q;
  logic                           acc_ovf_q;
  logic [NUM_BLK-1:0][CTR_W-1:0]  slot_q;

  // Out-of-range selects fall back to the last slot, for both the config
  // lookup and the slot written at close.
  always_comb begin
    sel_eff = SEL_W'(NUM_BLK - 1);
    if (32'(fe_sel) < 32'(NUM_BLK)) begin
      sel_eff = fe_sel;
    end
  end

  assign cfg_cur = fe_config[sel_eff];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cr_prefix_fe_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .cfg     (cfg_cur),
      .char_in (fe_char_in[8*i +: 8]),
      .vbyte   (fe_char_vbytes[i]),
      .prior   (fe_prior_in[i]),
      .match   (match_q[i])
    );
  end

  assign fe_prior_out = match_q;

  // Stage-1 sideband: keep eodb and the resolved select aligned with match_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eodb_d <= 1'b0;
      sel_d  <= '0;
    end else begin
      eodb_d <= fe_eodb;
      sel_d  <= sel_eff;
    end
  end

  // Number of matching lanes in the registered beat.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum = sum + SUM_W'(match_q[i]);
    end
  end

  // One extra bit on the add exposes the carry out as this beat's overflow;
  // saturation replaces only an overflowing result.
  assign nxt      = (CTR_W+1)'(acc_q) + (CTR_W+1)'(sum);
  assign beat_ovf = nxt[CTR_W];
  assign result   = (beat_ovf && fe_sat_mode) ? {CTR_W{1'b1}} : nxt[CTR_W-1:0];

  // Stage-2 accumulate / close / clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      slot_q     <= '0;
      fe_ctr_vld <= '0;
      fe_ovf     <= '0;
      fe_upd     <= 1'b0;
    end else if (fe_clr) begin
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      slot_q     <= '0;
      fe_ctr_vld <= '0;
      fe_ovf     <= '0;
      fe_upd     <= 1'b0;
    end else begin
      fe_upd <= eodb_d;
      if (eodb_d) begin
        slot_q[sel_d]     <= result;
        fe_ovf[sel_d]     <= acc_ovf_q | beat_ovf;
        fe_ctr_vld[sel_d] <= 1'b1;
        acc_q             <= '0;
        acc_ovf_q         <= 1'b0;
      end else begin
        acc_q     <= result;
        acc_ovf_q <= acc_ovf_q | beat_ovf;
      end
    end
  end

  assign fe_ctr_blk = slot_q;

endmodule

// File: tb/tb_cr_prefix_fe_ctr_gen.sv
// Bench for cr_prefix_fe_ctr_gen: directed scenarios followed by randomized
// blocks, all checked each cycle against a block-total reference model.
module tb_cr_prefix_fe_ctr_gen;
  import cr_prefix_pkg::*;

  localparam int NL   = 8;
  localparam int CW   = 8;
  localparam int NB   = 4;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [8*NL-1:0] ALL_A = {NL{8'h41}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  feature_t [NB-1:0]    fe_config;
  logic [SW-1:0]        fe_sel;
  logic [8*NL-1:0]      fe_char_in;
  logic [NL-1:0]        fe_char_vbytes;
  logic [NL-1:0]        fe_prior_in;
  logic                 fe_eodb;
  logic                 fe_clr;
  logic                 fe_sat_mode;
  logic [NL-1:0]        fe_prior_out;
  logic [NB*CW-1:0]     fe_ctr_blk;
  logic [NB-1:0]        fe_ctr_vld;
  logic [NB-1:0]        fe_ovf;
  logic                 fe_upd;

  cr_prefix_fe_ctr_gen #(.NUM_LANES(NL), .CTR_W(CW), .NUM_BLK(NB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fe_config      (fe_config),
    .fe_sel         (fe_sel),
    .fe_char_in     (fe_char_in),
    .fe_char_vbytes (fe_char_vbytes),
    .fe_prior_in    (fe_prior_in),
    .fe_eodb        (fe_eodb),
    .fe_clr         (fe_clr),
    .fe_sat_mode    (fe_sat_mode),
    .fe_prior_out   (fe_prior_out),
    .fe_ctr_blk     (fe_ctr_blk),
    .fe_ctr_vld     (fe_ctr_vld),
    .fe_ovf         (fe_ovf),
    .fe_upd         (fe_upd)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [NL-1:0] exp_q[$];
  int exp_total;
  int pend_sum;
  int pend_sel;
  bit pend_eodb;
  int exp_slot[NB];
  bit exp_vld[NB];
  bit exp_ovf[NB];
  bit exp_upd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_sel(input int s);
    return (s < NB) ? s : NB - 1;
  endfunction

  // Lane i matches when valid, masked-equal to the slot value, and (if
  // chaining is on) its prior bit is set.
  function automatic logic [NL-1:0] ref_match(input int sel, input logic [8*NL-1:0] ch,
                                              input logic [NL-1:0] vb, input logic [NL-1:0] pr);
    feature_t c;
    logic [NL-1:0] m;
    c = fe_config[clamp_sel(sel)];
    for (int i = 0; i < NL; i++) begin
      logic [7:0] b;
      b = ch[8*i +: 8];
      m[i] = vb[i] && ((b & c.mask) == (c.value & c.mask)) && (!c.prior_en || pr[i]);
    end
    return m;
  endfunction

  // Block-level behaviour: a block's count is the plain integer total of its
  // matches; at close it is reported saturated or modulo 2^CW, with the
  // overflow flag meaning "the total exceeded the counter range".
  task automatic model_stage2(input bit clr, input bit sat);
    if (clr) begin
      exp_total = 0;
      exp_upd   = 1'b0;
      for (int k = 0; k < NB; k++) begin
        exp_slot[k] = 0;
        exp_vld[k]  = 1'b0;
        exp_ovf[k]  = 1'b0;
      end
    end else begin
      exp_total = exp_total + pend_sum;
      exp_upd   = pend_eodb;
      if (pend_eodb) begin
        exp_slot[pend_sel] = sat ? ((exp_total > CMAX) ? CMAX : exp_total) : (exp_total % (CMAX + 1));
        exp_ovf[pend_sel]  = (exp_total > CMAX);
        exp_vld[pend_sel]  = 1'b1;
        exp_total = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_total = 0;
    pend_sum  = 0;
    pend_sel  = 0;
    pend_eodb = 1'b0;
    exp_upd   = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NB; k++) begin
      exp_slot[k] = 0;
      exp_vld[k]  = 1'b0;
      exp_ovf[k]  = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NB*CW-1:0] blk;
    logic [NB-1:0] v;
    logic [NB-1:0] o;
    for (int k = 0; k < NB; k++) begin
      blk[k*CW +: CW] = CW'(exp_slot[k]);
      v[k] = exp_vld[k];
      o[k] = exp_ovf[k];
    end
    chk({tag, "_blk"}, 64'(fe_ctr_blk), 64'(blk));
    chk({tag, "_vld"}, 64'(fe_ctr_vld), 64'(v));
    chk({tag, "_ovf"}, 64'(fe_ovf), 64'(o));
    chk({tag, "_upd"}, 64'(fe_upd), 64'(exp_upd));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drives one beat, lets one rising edge pass,
  // then checks stage 1 (this beat) and stage 2 (previous beat).
  task automatic beat(input int sel, input logic [8*NL-1:0] ch, input logic [NL-1:0] vb,
                      input logic [NL-1:0] pr, input bit eodb, input bit clr, input string tag);
    logic [NL-1:0] m;
    fe_sel         = SW'(sel);
    fe_char_in     = ch;
    fe_char_vbytes = vb;
    fe_prior_in    = pr;
    fe_eodb        = eodb;
    fe_clr         = clr;
    m = ref_match(int'(fe_sel), ch, vb, pr);
    exp_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
    model_stage2(clr, fe_sat_mode);
    pend_sum  = $countones(m);
    pend_eodb = eodb;
    pend_sel  = clamp_sel(int'(fe_sel));
    chk({tag, "_prior"}, 64'(fe_prior_out), 64'(exp_q.pop_front()));
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    beat(0, '0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    fe_sel = '0; fe_char_in = '0; fe_char_vbytes = '0; fe_prior_in = '0;
    fe_eodb = 1'b0; fe_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    chk({tag, "_prior"}, 64'(fe_prior_out), 64'(0));
    chk({tag, "_blk"}, 64'(fe_ctr_blk), 64'(0));
    chk({tag, "_vld"}, 64'(fe_ctr_vld), 64'(0));
    chk({tag, "_ovf"}, 64'(fe_ovf), 64'(0));
    chk({tag, "_upd"}, 64'(fe_upd), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_directed_cfg();
    for (int k = 0; k < NB; k++) begin
      fe_config[k].value    = 8'h41;
      fe_config[k].mask     = 8'hFF;
      fe_config[k].prior_en = 1'b0;
    end
  endtask

  task automatic set_random_cfg();
    for (int k = 0; k < NB; k++) begin
      int mk;
      fe_config[k].value = 8'($urandom_range(0, 255));
      mk = $urandom_range(0, 3);
      fe_config[k].mask  = (mk == 0) ? 8'hFF : (mk == 1) ? 8'hF0 : (mk == 2) ? 8'h00 : 8'($urandom_range(0, 255));
      fe_config[k].prior_en = ($urandom_range(0, 3) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_directed_cfg();
    fe_sat_mode = 1'b0;
    do_reset("reset");

    // Three full beats closed into slot 1.
    for (int b = 0; b < 3; b++) beat(1, ALL_A, '1, '0, b == 2, 1'b0, "blk3");
    idle("blk3_i1");
    chk("blk3_slot1", 64'(fe_ctr_blk[CW +: CW]), 64'(24));
    chk("blk3_vld1", 64'(fe_ctr_vld[1]), 64'(1));
    chk("blk3_upd", 64'(fe_upd), 64'(1));
    idle("blk3_i2");
    chk("blk3_upd_end", 64'(fe_upd), 64'(0));

    // Saturation, then an empty block rewrites the slot.
    fe_sat_mode = 1'b1;
    for (int b = 0; b < 40; b++) beat(2, ALL_A, '1, '0, b == 39, 1'b0, "sat");
    idle("sat_i");
    chk("sat_slot2", 64'(fe_ctr_blk[2*CW +: CW]), 64'(255));
    chk("sat_ovf2", 64'(fe_ovf[2]), 64'(1));
    beat(2, ALL_A, '0, '0, 1'b1, 1'b0, "empty");
    idle("empty_i");
    chk("empty_slot2", 64'(fe_ctr_blk[2*CW +: CW]), 64'(0));
    chk("empty_ovf2", 64'(fe_ovf[2]), 64'(0));

    // Wrap mode: 264 matches wrap to 8.
    fe_sat_mode = 1'b0;
    for (int b = 0; b < 33; b++) beat(0, ALL_A, '1, '0, b == 32, 1'b0, "wrap");
    idle("wrap_i");
    chk("wrap_slot0", 64'(fe_ctr_blk[0 +: CW]), 64'(8));
    chk("wrap_ovf0", 64'(fe_ovf[0]), 64'(1));

    // Clear coinciding with the stage-2 close.
    beat(3, ALL_A, '1, '0, 1'b0, 1'b0, "clr");
    beat(3, ALL_A, '1, '0, 1'b1, 1'b0, "clr");
    beat(0, '0, '0, '0, 1'b0, 1'b1, "clr_c");
    chk("clr_blk", 64'(fe_ctr_blk), 64'(0));
    chk("clr_vld", 64'(fe_ctr_vld), 64'(0));
    chk("clr_upd", 64'(fe_upd), 64'(0));

    // Partial lanes with an out-of-range select (7 on a 2-bit port).
    for (int b = 0; b < 3; b++) beat(7, ALL_A, 8'h0F, '0, b == 2, 1'b0, "half");
    idle("half_i");
    chk("half_blk", 64'(fe_ctr_blk), 64'(32'h0C00_0000));
    chk("half_vld", 64'(fe_ctr_vld), 64'(4'b1000));

    // Reset in mid-block, then a fresh 2-beat block.
    for (int b = 0; b < 5; b++) beat(1, ALL_A, '1, '0, 1'b0, 1'b0, "mid");
    do_reset("mid_rst");
    for (int b = 0; b < 2; b++) beat(1, ALL_A, '1, '0, b == 1, 1'b0, "post");
    idle("post_i");
    chk("post_slot1", 64'(fe_ctr_blk[CW +: CW]), 64'(16));

    // Randomized blocks.
    for (int blk = 0; blk < 150; blk++) begin
      int len;
      int sel;
      set_random_cfg();
      fe_sat_mode = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(30, 40) : $urandom_range(1, 10);
      sel = $urandom_range(0, NB - 1);
      for (int b = 0; b < len; b++) begin
        logic [8*NL-1:0] ch;
        logic [NL-1:0] vb;
        feature_t c;
        c = fe_config[sel];
        for (int i = 0; i < NL; i++) begin
          logic [7:0] rnd;
          rnd = 8'($urandom_range(0, 255));
          ch[8*i +: 8] = ($urandom_range(0, 3) != 0) ? (c.value ^ (rnd & ~c.mask)) : rnd;
          vb[i] = ($urandom_range(0, 4) != 0);
        end
        beat(sel, ch, vb, NL'($urandom_range(0, 255)), b == len - 1,
             $urandom_range(0, 40) == 0, "rnd");
      end
      for (int g = 0; g < int'($urandom_range(1, 2)); g++) idle("rnd_gap");
      if ($urandom_range(0, 25) == 0) do_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
